// File: rtl/dm_pkg.sv
`default_nettype none
//==============================================================================
// Module : dm_pkg
// Brief  : Shared encodings, state type and helper functions for the
//          data-memory access unit.
// Rev    : 1.0  initial release
//==============================================================================
package dm_pkg;

   localparam int unsigned DM_WORDS = 3072;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ISSUE   = 2'd1,
      S_CAPTURE = 2'd2,
      S_RESP    = 2'd3
   } dm_state_e;

   // Byte-lane write enables for a store of the given size at a byte offset
   function automatic logic [3:0] wea_gen(input logic [1:0] size, input logic [1:0] off);
      logic [3:0] m;
      m = 4'b0000;
      case (size)
         SZ_BYTE: m = 4'b0001 << off;
         SZ_HALF: m = off[1] ? 4'b1100 : 4'b0011;
         SZ_WORD: m = 4'b1111;
         default: m = 4'b0000;
      endcase
      return m;
   endfunction

   // Select the addressed lane of a RAM word and sign/zero-extend it
   function automatic logic [31:0] load_extend(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic [1:0]  off,
                                               input logic        is_unsigned);
      logic [31:0] lane;
      logic [31:0] r;
      lane = word >> {off, 3'b000};
      case (size)
         SZ_BYTE: r = is_unsigned ? {24'd0, lane[7:0]}  : {{24{lane[7]}},  lane[7:0]};
         SZ_HALF: r = is_unsigned ? {16'd0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
         default: r = word;
      endcase
      return r;
   endfunction

endpackage : dm_pkg
`default_nettype wire

// File: rtl/dm_load_align.sv
`default_nettype none
//==============================================================================
// Module : dm_load_align
// Brief  : Combinational load lane select and sign/zero extension.
// Rev    : 1.0  initial release
//==============================================================================
module dm_load_align (
   input  logic [31:0] word,
   input  logic [1:0]  size,
   input  logic [1:0]  off,
   input  logic        is_unsigned,
   output logic [31:0] data
);
   import dm_pkg::*;

   // Pure lane select and extend of the registered RAM word
   always_comb begin
      data = load_extend(word, size, off, is_unsigned);
   end

endmodule : dm_load_align
`default_nettype wire

// File: rtl/dm_access_unit.sv
`default_nettype none
//==============================================================================
// Module : dm_access_unit
// Brief  : MEM-stage load/store initiator driving a one-cycle-latency data RAM.
//          One access in flight; faults are answered without touching the RAM.
// Rev    : 1.0  initial release
//==============================================================================
module dm_access_unit #(
   parameter int unsigned DM_WORDS = dm_pkg::DM_WORDS,
   parameter int unsigned AW_HI    = 13
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_fault,
   output logic [AW_HI-2:0]  dm_addra,
   output logic              dm_ena,
   output logic [3:0]        dm_wea,
   output logic [31:0]       dm_dina,
   input  logic [31:0]       dm_douta
);
   import dm_pkg::*;

   dm_state_e         r_state;
   dm_state_e         w_state_nxt;

   logic              r_we;
   logic [1:0]        r_size;
   logic [1:0]        r_off;
   logic              r_uns;

   logic              w_fault;
   logic [31:0]       w_load_data;

   logic              w_ena_nxt;
   logic [3:0]        w_wea_nxt;
   logic [AW_HI-2:0]  w_addra_nxt;
   logic [31:0]       w_dina_nxt;
   logic              w_rv_nxt;
   logic [31:0]       w_rd_nxt;
   logic              w_rf_nxt;

   // Ready is withheld while reset is held so nothing is accepted then
   assign req_ready = (r_state == S_IDLE) && !rst;

   // Reject reserved size, misalignment and word indices beyond the RAM
   always_comb begin
      w_fault = 1'b0;
      if (req_size == 2'd3)                             w_fault = 1'b1;
      if ((req_size == SZ_HALF) && req_addr[0])         w_fault = 1'b1;
      if ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00)) w_fault = 1'b1;
      if ({2'b00, req_addr[31:2]} >= DM_WORDS)          w_fault = 1'b1;
   end

   dm_load_align u_align (
      .word        (dm_douta),
      .size        (r_size),
      .off         (r_off),
      .is_unsigned (r_uns),
      .data        (w_load_data)
   );

   // Next state and next values of every registered RAM/response output;
   // RAM enables default low so only the ISSUE cycle can touch the RAM
   always_comb begin
      w_state_nxt = r_state;
      w_ena_nxt   = 1'b0;
      w_wea_nxt   = 4'b0000;
      w_addra_nxt = dm_addra;
      w_dina_nxt  = dm_dina;
      w_rv_nxt    = 1'b0;
      w_rd_nxt    = 32'd0;
      w_rf_nxt    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (req_valid) begin
               if (w_fault) begin
                  w_state_nxt = S_RESP;
                  w_rv_nxt    = 1'b1;
                  w_rf_nxt    = 1'b1;
               end else begin
                  w_state_nxt = S_ISSUE;
                  w_ena_nxt   = 1'b1;
                  w_wea_nxt   = req_we ? wea_gen(req_size, req_addr[1:0]) : 4'b0000;
                  w_addra_nxt = req_addr[AW_HI:2];
                  // RAM steers the low byte/half into the enabled lanes itself
                  w_dina_nxt  = req_wdata;
               end
            end
         end
         S_ISSUE: begin
            if (r_we) begin
               w_state_nxt = S_RESP;
               w_rv_nxt    = 1'b1;
            end else begin
               w_state_nxt = S_CAPTURE;
            end
         end
         S_CAPTURE: begin
            w_state_nxt = S_RESP;
            w_rv_nxt    = 1'b1;
            w_rd_nxt    = w_load_data;
         end
         S_RESP: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Request latch plus registered RAM-side and response outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_we       <= 1'b0;
         r_size     <= 2'd0;
         r_off      <= 2'd0;
         r_uns      <= 1'b0;
         dm_ena     <= 1'b0;
         dm_wea     <= 4'b0000;
         dm_addra   <= '0;
         dm_dina    <= 32'd0;
         resp_valid <= 1'b0;
         resp_rdata <= 32'd0;
         resp_fault <= 1'b0;
      end else begin
         if ((r_state == S_IDLE) && req_valid) begin
            r_we   <= req_we;
            r_size <= req_size;
            r_off  <= req_addr[1:0];
            r_uns  <= req_unsigned;
         end
         dm_ena     <= w_ena_nxt;
         dm_wea     <= w_wea_nxt;
         dm_addra   <= w_addra_nxt;
         dm_dina    <= w_dina_nxt;
         resp_valid <= w_rv_nxt;
         resp_rdata <= w_rd_nxt;
         resp_fault <= w_rf_nxt;
      end
   end

endmodule : dm_access_unit
`default_nettype wire

// File: tb/tb_dm_access_unit.sv
`default_nettype none
//==============================================================================
// Module : tb_dm_access_unit
// Brief  : Self-checking bench for dm_access_unit with a byte-level memory
//          reference model and a one-cycle-latency RAM model.
// Rev    : 1.0  initial release
//==============================================================================
module tb_dm_access_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_fault;
   logic [11:0] dm_addra;
   logic        dm_ena;
   logic [3:0]  dm_wea;
   logic [31:0] dm_dina;
   logic [31:0] dm_douta;

   int n_chk  = 0;
   int n_fail = 0;

   logic [31:0] ram [0:4095];
   logic [7:0]  ref_mem [0:12287];
   logic        ram_init;
   logic        prev_ena = 1'b0;

   always #5 clk = ~clk;

   dm_access_unit dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .resp_valid   (resp_valid),
      .resp_rdata   (resp_rdata),
      .resp_fault   (resp_fault),
      .dm_addra     (dm_addra),
      .dm_ena       (dm_ena),
      .dm_wea       (dm_wea),
      .dm_dina      (dm_dina),
      .dm_douta     (dm_douta)
   );

   function automatic logic [31:0] init_word(input int i);
      return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A1234;
   endfunction

   // RAM: registered read-first port; byte store uses dina[7:0], half uses dina[15:0]
   always @(posedge clk) begin
      if (ram_init) begin
         for (int i = 0; i < 4096; i++) ram[i] <= init_word(i);
      end else if (dm_ena) begin
         dm_douta <= ram[dm_addra];
         for (int l = 0; l < 4; l++) begin
            if (dm_wea[l]) begin
               case (dm_wea)
                  4'b1111:          ram[dm_addra][8*l +: 8] <= dm_dina[8*l +: 8];
                  4'b0011, 4'b1100: ram[dm_addra][8*l +: 8] <= dm_dina[8*(l%2) +: 8];
                  default:          ram[dm_addra][8*l +: 8] <= dm_dina[7:0];
               endcase
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Cycle-level invariants on the RAM port and handshake
   always @(negedge clk) begin
      if (!rst && !ram_init) begin
         chk("wea_without_ena", {31'd0, (dm_wea != 4'b0000) && !dm_ena}, 32'd0);
         chk("ena_two_cycles",  {31'd0, dm_ena && prev_ena}, 32'd0);
         chk("ready_while_busy", {31'd0, req_ready && (dm_ena || resp_valid)}, 32'd0);
      end
      prev_ena <= dm_ena;
   end

   // One complete transaction checked against the reference model
   task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] got);
      int          n, exp_lat, waitc, lat;
      logic        exp_fault, seen_ena, ena1, got_fault;
      logic [31:0] exp_rd, addra1, dina1;
      logic [3:0]  wea1, exp_wea;
      n         = 1 << size;
      exp_fault = (size == 2'd3) || ((addr % n) != 0) || ((addr >> 2) >= 3072);
      exp_rd    = 32'd0;
      if (!exp_fault && !we) begin
         for (int i = 0; i < n; i++) exp_rd |= 32'(ref_mem[addr + i]) << (8 * i);
         if (n < 4 && !uns && exp_rd[8*n-1]) exp_rd |= 32'hFFFF_FFFF << (8 * n);
      end
      exp_lat = exp_fault ? 1 : (we ? 2 : 3);
      exp_wea = we ? 4'(((1 << n) - 1) << (addr % 4)) : 4'b0000;
      got       = 'x;
      got_fault = 1'bx;

      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
      req_addr = addr; req_wdata = wdata;
      waitc = 0;
      while (!req_ready && waitc < 20) begin
         @(negedge clk);
         waitc++;
      end
      chk("accept_ready", {31'd0, req_ready}, 32'd1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_we = 1'($urandom); req_size = 2'($urandom); req_addr = $urandom; req_wdata = $urandom;
      if (we && !exp_fault)
         for (int i = 0; i < n; i++) ref_mem[addr + i] = wdata[8*i +: 8];

      lat = 0; seen_ena = 1'b0; ena1 = 1'b0; wea1 = '0; addra1 = '0; dina1 = '0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (k == 1) begin
            ena1 = dm_ena; wea1 = dm_wea; addra1 = {20'd0, dm_addra}; dina1 = dm_dina;
         end
         if (dm_ena) seen_ena = 1'b1;
         if (resp_valid) begin
            lat = k; got = resp_rdata; got_fault = resp_fault;
            break;
         end
      end
      chk("latency", 32'(lat), 32'(exp_lat));
      chk("resp_fault", {31'd0, got_fault}, {31'd0, exp_fault});
      chk("resp_rdata", got, exp_rd);
      if (exp_fault) begin
         chk("fault_no_ena", {31'd0, seen_ena}, 32'd0);
      end else begin
         chk("issue_ena", {31'd0, ena1}, 32'd1);
         chk("issue_addra", addra1, addr >> 2);
         chk("issue_wea", {28'd0, wea1}, {28'd0, exp_wea});
         if (we) chk("issue_dina", dina1, wdata);
      end
      @(negedge clk);
      chk("resp_one_pulse", {31'd0, resp_valid}, 32'd0);
   endtask

   initial begin : main
      logic [31:0] got, exp_load;
      int          gap, resp_cnt, thr_prev;
      logic        bad;

      rst = 1'b1; ram_init = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
      req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
      for (int b = 0; b < 12288; b++) ref_mem[b] = 8'(init_word(b / 4) >> (8 * (b % 4)));
      @(negedge clk);
      ram_init = 1'b0;
      @(negedge clk);

      // Reset state
      chk("rst_ready", {31'd0, req_ready}, 32'd0);
      chk("rst_ena",   {31'd0, dm_ena},    32'd0);
      chk("rst_wea",   {28'd0, dm_wea},    32'd0);
      chk("rst_addra", {20'd0, dm_addra},  32'd0);
      chk("rst_dina",  dm_dina,            32'd0);
      chk("rst_rv",    {31'd0, resp_valid}, 32'd0);
      chk("rst_rdata", resp_rdata,         32'd0);
      chk("rst_fault", {31'd0, resp_fault}, 32'd0);
      rst = 1'b0;
      #1;
      chk("ready_after_rst", {31'd0, req_ready}, 32'd1);

      // Word store then load
      do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, got);
      do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, got);
      chk("word_load", got, 32'hDEADBEEF);

      // Byte store, signed and unsigned byte loads
      do_req(1'b1, 2'd0, 1'b0, 32'h13, 32'h80, got);
      do_req(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, got);
      chk("lb_signed", got, 32'hFFFFFF80);
      do_req(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, got);
      chk("lb_unsigned", got, 32'h00000080);

      // Half store to upper half, half and word loads
      do_req(1'b1, 2'd1, 1'b0, 32'h22, 32'h1234, got);
      do_req(1'b0, 2'd1, 1'b1, 32'h22, 32'h0, got);
      chk("lhu", got, 32'h00001234);
      do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, got);
      chk("word_upper_half", {16'd0, got[31:16]}, 32'h00001234);

      // Faults
      do_req(1'b0, 2'd2, 1'b0, 32'h6,    32'h0, got);
      do_req(1'b1, 2'd1, 1'b0, 32'h3,    32'h5555, got);
      do_req(1'b0, 2'd2, 1'b0, 32'h3000, 32'h0, got);
      do_req(1'b0, 2'd3, 1'b0, 32'h40,   32'h0, got);
      do_req(1'b0, 2'd2, 1'b0, 32'h2FFC, 32'h0, got);

      // Reset during CAPTURE drops the load
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h10;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrst_ready", {31'd0, req_ready}, 32'd0);
      chk("midrst_ena",   {31'd0, dm_ena},    32'd0);
      chk("midrst_wea",   {28'd0, dm_wea},    32'd0);
      chk("midrst_rv",    {31'd0, resp_valid}, 32'd0);
      chk("midrst_rdata", resp_rdata,         32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("midrst_ready_back", {31'd0, req_ready}, 32'd1);
      bad = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (resp_valid) bad = 1'b1;
      end
      chk("midrst_no_resp", {31'd0, bad}, 32'd0);

      // Back-to-back with req_valid held high, alternating store/load at 0x40
      @(negedge clk);
      req_valid = 1'b1;
      resp_cnt = 0; thr_prev = 0; exp_load = 32'd0;
      for (int t = 0; t < 6; t++) begin
         req_we = (t % 2 == 0); req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h40;
         req_wdata = $urandom;
         gap = 0;
         while (!req_ready && gap < 20) begin
            @(negedge clk);
            gap++;
            if (resp_valid) begin
               resp_cnt++;
               if ((t - 1) % 2 == 1) chk("b2b_load", resp_rdata, exp_load);
            end
         end
         if (t > 0) chk("b2b_gap", 32'(gap), 32'(thr_prev));
         chk("b2b_resp_count", 32'(resp_cnt), 32'(t));
         if (req_we) begin
            for (int i = 0; i < 4; i++) ref_mem[32'h40 + i] = req_wdata[8*i +: 8];
            thr_prev = 3;
         end else begin
            exp_load = 32'd0;
            for (int i = 0; i < 4; i++) exp_load |= 32'(ref_mem[32'h40 + i]) << (8 * i);
            thr_prev = 4;
         end
         @(posedge clk);
         #1;
      end
      req_valid = 1'b0;
      bad = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (resp_valid) begin
            bad = 1'b0;
            chk("b2b_last_load", resp_rdata, exp_load);
            break;
         end
      end
      chk("b2b_last_seen", {31'd0, bad}, 32'd0);

      // Randomized accesses against the model
      for (int r = 0; r < 60; r++) begin
         int sel;
         logic [31:0] a;
         sel = $urandom_range(0, 9);
         if (sel == 0)      a = 32'h3000 + $urandom_range(0, 255);
         else if (sel == 1) a = $urandom;
         else               a = $urandom_range(0, 127);
         do_req(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), a, $urandom, got);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule : tb_dm_access_unit
`default_nettype wire
